stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Single-clock, parametrised successor to the stopwatch time counter: keeps an MM:SS value that counts up or down on a run-rate tick enable. Supports pause toggling and field-wise manual adjust on a faster adjust-rate tick. Sits between the clock-enable divider (which supplies `tick_run`/`tick_adj` pulses) and the seven-segment display driver (which consumes `minutes`/`seconds`). All multi-clock usage of the previous generation is replaced by one clock plus enables.

## Interface
- `MIN_W`, 6, width of minutes field
- `SEC_W`, 6, width of seconds field
- `MIN_MAX`, 59, highest minutes value; must fit in `MIN_W`
- `SEC_MAX`, 59, highest seconds value; must fit in `SEC_W`

- `clk`  in  1  single system clock; all logic is on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `tick_run`  in  1  one-cycle run-rate enable (nominally 1 Hz)
- `tick_adj`  in  1  one-cycle adjust-rate enable (nominally 2 Hz)
- `adj`  in  1  level; 1 = adjust mode, 0 = run mode
- `sel`  in  1  adjust field select: 0 = minutes, 1 = seconds
- `pause_btn`  in  1  debounced level; each rising edge toggles `paused`
- `dir`  in  1  0 = count up, 1 = count down
- `minutes`  out  `MIN_W`  current minutes
- `seconds`  out  `SEC_W`  current seconds
- `paused`  out  1  pause state
- `wrap`  out  1  one-cycle pulse on up-count wrap MAX:MAX -> 00:00
- `expired`  out  1  level; down-count has reached 00:00 and is holding

## Operation
- Reset (`rst_n`=0, async): `minutes`=0, `seconds`=0, `paused`=0, `wrap`=0, `expired`=0, pause edge register=0.
- Pause: rising edge of `pause_btn` (sampled vs previous-cycle register) toggles `paused`. While `paused`=1, neither run nor adjust changes the value.
- Run mode (`adj`=0, `paused`=0), on `tick_run`:
  - Up: seconds+1. At `SEC_MAX`, seconds->0 and minutes+1. At `MIN_MAX`:`SEC_MAX`, both go to 0 and `wrap` pulses.
  - Down: seconds-1. At 0, seconds->`SEC_MAX` and minutes-1. At 00:00 the value holds, and `expired` sets and stays set.
- Adjust mode (`adj`=1, `paused`=0), on `tick_adj`:
  - Increment only the selected field. It wraps at its own MAX to 0, with no carry into the other field and no `wrap` pulse.
  - `tick_run` is ignored in adjust mode.
- `expired` clears on: any adjust increment, `dir` going to 0, or reset. While `expired`=1 with `dir`=1, `tick_run` does nothing.
- Values above MAX are unreachable; no handling is required.

## Timing
- All outputs are registered. A tick at cycle N is reflected in outputs after the edge ending cycle N (latency 1).
- `wrap` is high for exactly the cycle following the wrapping tick.
- Pause edge and tick in the same cycle: the tick is evaluated with the pre-toggle `paused`. Toggle and count both take effect at the same edge.
- `tick_run` and `tick_adj` in the same cycle: only the one matching the current mode acts.
- `adj`, `sel` and `dir` changes take effect for ticks in the same cycle they are sampled. No extra latency.
- Mid-operation reset: outputs go to reset values immediately and asynchronously. Counting resumes on the first tick after `rst_n` is released.

## Structure
- `stopwatch_pkg`: the default-width/max localparams and the mode encoding (`MODE_RUN`, `MODE_ADJ`). The display driver reuses them.
- One sub-module, `mod_counter`:
  - Parametrised width and MAX; inputs `inc`, `dec`; outputs `carry`/`borrow`; wraps in both directions.
  - Instantiated twice (seconds, minutes). The top-level handles pause, mode, and the hold/`expired` logic.

## Test plan
- Reset then 60 `tick_run`, up -> 01:00 after the 60th tick. At 59:59, one more tick -> 00:00 with `wrap`=1 for one cycle.
- `dir`=1 from 01:00, 60 ticks -> 00:00 with `expired`=1. 5 further ticks -> still 00:00. Set `dir`=0 -> `expired`=0, and the next tick gives 00:01.
- Pulse `pause_btn` at 00:10, then 5 `tick_run` -> value stays 00:10. Pulse again, then 1 tick -> 00:11.
- `adj`=1, `sel`=1 at 00:58, 3 `tick_adj` -> 00:01 with minutes unchanged. `sel`=0 at 59:xx, 1 `tick_adj` -> 00:xx with no `wrap`. Concurrent `tick_run` pulses are ignored.
- Same-cycle `pause_btn` edge and `tick_run` at 00:05 -> 00:06 and `paused`=1. The next tick leaves the value at 00:06.
- Assert `rst_n`=0 asynchronously mid-count at 12:34 -> outputs go to 00:00 and `paused`=0 before the next clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants and mode encoding (also used by the display driver).
package stopwatch_pkg;

  localparam int MIN_W_DEF   = 6;
  localparam int SEC_W_DEF   = 6;
  localparam int MIN_MAX_DEF = 59;
  localparam int SEC_MAX_DEF = 59;

  // Operating mode, taken directly from the adj level input.
  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_ADJ = 1'b1
  } mode_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up/down counter with combinational carry/borrow flags.
module mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         carry,
  output logic         borrow
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // carry/borrow flag the wrap that this cycle's step will perform
  assign carry  = inc && (cnt_q == MAX_V);
  assign borrow = dec && (cnt_q == '0);
  assign value  = cnt_q;

  // Next value: inc has priority; both directions wrap within 0..MAX
  always_comb begin
    cnt_d = cnt_q;
    if (inc)      cnt_d = carry  ? '0    : cnt_q + 1'b1;
    else if (dec) cnt_d = borrow ? MAX_V : cnt_q - 1'b1;
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch: run/adjust modes on tick enables, pause toggle, wrap/expired flags.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_W   = MIN_W_DEF,
  parameter int SEC_W   = SEC_W_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_run,
  input  logic             tick_adj,
  input  logic             adj,
  input  logic             sel,
  input  logic             pause_btn,
  input  logic             dir,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             paused,
  output logic             wrap,
  output logic             expired
);

  mode_e mode;
  logic  pause_btn_q;
  logic  paused_q, paused_d;
  logic  wrap_q, wrap_d;
  logic  expired_q, expired_d;

  logic  run_act, adj_act, run_up, run_down;
  logic  at_zero, reach_zero;
  logic  sec_inc, sec_dec, min_inc, min_dec;
  logic  sec_carry, sec_borrow, min_carry, min_borrow_unused;

  assign mode = mode_e'(adj);

  // Ticks are qualified with the pre-toggle pause state
  assign run_act  = tick_run && !paused_q && (mode == MODE_RUN);
  assign adj_act  = tick_adj && !paused_q && (mode == MODE_ADJ);
  assign run_up   = run_act && !dir;
  assign run_down = run_act &&  dir;

  assign at_zero    = (minutes == '0) && (seconds == '0);
  // A down step from 00:01 lands on 00:00, which counts as reaching zero
  assign reach_zero = (minutes == '0) && (seconds == SEC_W'(1));

  // Field steps: adjust touches one field only; down-count freezes at 00:00
  assign sec_inc = run_up || (adj_act && sel);
  assign min_inc = (run_up && sec_carry) || (adj_act && !sel);
  assign sec_dec = run_down && !at_zero && !expired_q;
  assign min_dec = sec_dec && sec_borrow;

  mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (sec_inc),
    .dec    (sec_dec),
    .value  (seconds),
    .carry  (sec_carry),
    .borrow (sec_borrow)
  );

  mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (min_inc),
    .dec    (min_dec),
    .value  (minutes),
    .carry  (min_carry),
    .borrow (min_borrow_unused)
  );

  // Next-state for pause, wrap pulse and expired hold flag
  always_comb begin
    paused_d  = paused_q ^ (pause_btn && !pause_btn_q);
    wrap_d    = run_up && sec_carry && min_carry;
    expired_d = expired_q;
    if (adj_act || !dir)                          expired_d = 1'b0;
    else if (run_down && (at_zero || reach_zero)) expired_d = 1'b1;
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_btn_q <= 1'b0;
      paused_q    <= 1'b0;
      wrap_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      pause_btn_q <= pause_btn;
      paused_q    <= paused_d;
      wrap_q      <= wrap_d;
      expired_q   <= expired_d;
    end
  end

  assign paused  = paused_q;
  assign wrap    = wrap_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; all values checked at the falling edge.
module tb_stopwatch_counter;

  logic       clk, rst_n;
  logic       tick_run, tick_adj, adj, sel, pause_btn, dir;
  logic [5:0] minutes, seconds;
  logic       paused, wrap, expired;

  int checks = 0;
  int errors = 0;

  stopwatch_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_run  (tick_run),
    .tick_adj  (tick_adj),
    .adj       (adj),
    .sel       (sel),
    .pause_btn (pause_btn),
    .dir       (dir),
    .minutes   (minutes),
    .seconds   (seconds),
    .paused    (paused),
    .wrap      (wrap),
    .expired   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int m, input int s);
    check({tag, ".min"}, 32'(minutes), 32'(m));
    check({tag, ".sec"}, 32'(seconds), 32'(s));
  endtask

  // One-cycle pulse on any of the strobes, returning at the falling edge
  // after the registering rising edge.
  task automatic step(input logic r, input logic a, input logic p);
    @(negedge clk);
    tick_run = r; tick_adj = a; pause_btn = p;
    @(negedge clk);
    tick_run = 1'b0; tick_adj = 1'b0; pause_btn = 1'b0;
  endtask

  task automatic runs(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic adjs(input int n, input logic with_run);
    for (int i = 0; i < n; i++) step(with_run, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; tick_run = 1'b0; tick_adj = 1'b0; adj = 1'b0;
    sel = 1'b0; pause_btn = 1'b0; dir = 1'b0;
    #22;
    check_time("reset", 0, 0);
    check("reset.paused", 32'(paused), 0);
    check("reset.wrap", 32'(wrap), 0);
    check("reset.expired", 32'(expired), 0);
    @(negedge clk); rst_n = 1'b1;

    // Up-count with minute carry
    runs(59);
    check_time("up59", 0, 59);
    runs(1);
    check_time("up60", 1, 0);
    check("up60.wrap", 32'(wrap), 0);
    runs(3539);
    check_time("at5959", 59, 59);
    runs(1);
    check_time("wrap", 0, 0);
    check("wrap.pulse", 32'(wrap), 1);
    @(negedge clk);
    check("wrap.oneshot", 32'(wrap), 0);

    // Down-count to expiry and hold
    runs(60);
    check_time("up_to_0100", 1, 0);
    dir = 1'b1;
    runs(1);
    check_time("down1", 0, 59);
    runs(58);
    check_time("down59", 0, 1);
    check("down59.expired", 32'(expired), 0);
    runs(1);
    check_time("down60", 0, 0);
    check("down60.expired", 32'(expired), 1);
    runs(5);
    check_time("hold", 0, 0);
    check("hold.expired", 32'(expired), 1);
    dir = 1'b0;
    @(negedge clk);
    check("dir0.expired", 32'(expired), 0);
    runs(1);
    check_time("after_expire", 0, 1);

    // Pause freezes run counting
    runs(9);
    check_time("at0010", 0, 10);
    step(1'b0, 1'b0, 1'b1);
    check("pause.on", 32'(paused), 1);
    runs(5);
    check_time("paused", 0, 10);
    step(1'b0, 1'b0, 1'b1);
    check("pause.off", 32'(paused), 0);
    runs(1);
    check_time("resumed", 0, 11);

    // Adjust seconds with concurrent run ticks ignored
    runs(47);
    check_time("at0058", 0, 58);
    adj = 1'b1; sel = 1'b1;
    adjs(3, 1'b1);
    check_time("adj_sec", 0, 1);
    runs(3);
    check_time("adj_runign", 0, 1);
    sel = 1'b0;
    adjs(59, 1'b0);
    check_time("adj_min59", 59, 1);
    adjs(1, 1'b1);
    check_time("adj_minwrap", 0, 1);
    check("adj_minwrap.wrap", 32'(wrap), 0);

    // Adjust increment clears expired
    adj = 1'b0; dir = 1'b1;
    runs(1);
    check_time("exp2", 0, 0);
    check("exp2.expired", 32'(expired), 1);
    adj = 1'b1; sel = 1'b1;
    adjs(1, 1'b0);
    check_time("adj_clr", 0, 1);
    check("adj_clr.expired", 32'(expired), 0);
    adj = 1'b0; dir = 1'b0;

    // Pause edge and run tick together
    runs(4);
    check_time("at0005", 0, 5);
    step(1'b1, 1'b0, 1'b1);
    check_time("same_cycle", 0, 6);
    check("same_cycle.paused", 32'(paused), 1);
    runs(1);
    check_time("same_cycle_hold", 0, 6);
    step(1'b0, 1'b0, 1'b1);
    check("unpause2", 32'(paused), 0);

    // Asynchronous reset mid-count
    adj = 1'b1; sel = 1'b0;
    adjs(12, 1'b0);
    sel = 1'b1;
    adjs(28, 1'b0);
    adj = 1'b0;
    check_time("at1234", 12, 34);
    step(1'b0, 1'b0, 1'b1);
    check("pre_rst.paused", 32'(paused), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_time("async_rst", 0, 0);
    check("async_rst.paused", 32'(paused), 0);
    @(negedge clk); rst_n = 1'b1;
    runs(1);
    check_time("post_rst", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
